instruction_fetch_unit: RTL and testbench

- Read-side master for the synchronous instruction memory. Owns the program counter, drives the word address, and captures the returned instruction one cycle later.
- Presents instructions to decode over a valid/ready handshake.
- Sits between the instruction memory and the decode/condition-check stage. Accepts branch redirects from execute.

---
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues synchronous imem reads and buffers returned words in a
// 2-entry FIFO for decode. Build with FETCH_ZERO_HALT_EN to stop fetching after an all-zero word.
module instruction_fetch_unit #(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 32,
  parameter int MEM_DEPTH = 32,
  parameter int RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
`ifdef FETCH_ZERO_HALT_EN
  output logic               halted,
`endif
  output logic               busy
);

  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC) & PC_MASK;

  logic [ADDR_W-1:0]  req_pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic [INSTR_W-1:0] buf_instr [2];
  logic [ADDR_W-1:0]  buf_pc    [2];
  logic               rd_ptr;
  logic [1:0]         count;

  logic       pop;
  logic       push;
  logic       wr_ptr;
  logic       issue;
  logic       halt_block;
  logic [2:0] occ_after;

  assign pop       = (count != 2'd0) && out_ready;
  assign push      = inflight;
  assign wr_ptr    = rd_ptr ^ count[0];
  // Entries that would be held after this edge if nothing new were issued.
  assign occ_after = 3'(count) + 3'(inflight) - 3'(pop);

`ifdef FETCH_ZERO_HALT_EN
  logic halt_q;

  // The zero word's own push edge already blocks the next issue.
  assign halt_block = halt_q || (push && (imem_instruction == '0));
  assign halted     = halt_q;

  always_ff @(posedge clk) begin
    if (reset || branch_valid) begin
      halt_q <= 1'b0;
    end else if (push && (imem_instruction == '0)) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_block = 1'b0;
`endif

  assign issue = (occ_after <= 3'd1) && !halt_block;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc       <= PC_INIT;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
    end else if (branch_valid) begin
      // Redirect drops the FIFO and any data returning this edge.
      req_pc   <= branch_target & PC_MASK;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= imem_instruction;
        buf_pc[wr_ptr]    <= inflight_pc;
      end
      count    <= count + {1'b0, push} - {1'b0, pop};
      rd_ptr   <= rd_ptr ^ pop;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= req_pc;
        req_pc      <= (req_pc + ADDR_W'(1)) & PC_MASK;
      end
    end
  end

  assign imem_address = req_pc;
  assign out_valid    = (count != 2'd0);
  assign out_instr    = buf_instr[rd_ptr];
  assign out_pc       = buf_pc[rd_ptr];
  assign busy         = inflight || (count != 2'd0);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the model predicts the delivered PC stream from
// the last restart point; a negedge monitor checks every presented and accepted instruction.
module tb_instruction_fetch_unit;
  localparam int AW    = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 32;
  localparam int RPC   = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_address;
  logic [IW-1:0] imem_instruction;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          busy;
`ifdef FETCH_ZERO_HALT_EN
  logic          halted;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .MEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_address(imem_address),
    .imem_instruction(imem_instruction),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
`ifdef FETCH_ZERO_HALT_EN
    .halted(halted),
`endif
    .busy(busy)
  );

  // Synchronous instruction memory: one-cycle read latency.
  logic [IW-1:0] mem [DEPTH];
  always @(posedge clk) imem_instruction <= mem[imem_address[4:0]];

  int checks   = 0;
  int failures = 0;

  // Reference model: the stream since the last restart is start, start+1, ... mod DEPTH,
  // ending at (and including) the first zero word when zero-halt is built in.
  logic [AW-1:0] qpc  [$];
  logic [IW-1:0] qins [$];
  int gen_pc   = RPC;
  bit gen_done = 1'b0;
  int since    = 0;
  bit started  = 1'b0;
  bit rst_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (qpc.size() < 4 && !gen_done) begin
      qpc.push_back(AW'(gen_pc));
      qins.push_back(mem[gen_pc]);
`ifdef FETCH_ZERO_HALT_EN
      if (mem[gen_pc] == '0) gen_done = 1'b1;
`endif
      gen_pc = (gen_pc + 1) % DEPTH;
    end
  endtask

  task automatic restart(input int p);
    qpc.delete();
    qins.delete();
    gen_pc   = p;
    gen_done = 1'b0;
    since    = 0;
  endtask

  task automatic step(input bit rdy, input bit bv, input logic [AW-1:0] tgt, input bit rst);
    out_ready     = rdy;
    branch_valid  = bv;
    branch_target = tgt;
    reset         = rst;
    @(posedge clk);
    #1;
    if (rst) started = 1'b1;
    rst_seen = rst;
    if (rst) restart(RPC);
    else if (bv) restart(int'(tgt) % DEPTH);
    else if (since < 4) since++;
    refill();
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (rst_seen) begin
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_instr", {32'd0, out_instr}, 64'd0);
        chk("reset_out_pc", {48'd0, out_pc}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
`ifdef FETCH_ZERO_HALT_EN
        chk("reset_halted", {63'd0, halted}, 64'd0);
`endif
      end else begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, (since >= 2 && qpc.size() > 0)});
        chk("busy", {63'd0, busy}, {63'd0, (since >= 1 && qpc.size() > 0)});
        chk("imem_address_range", {63'd0, (int'(imem_address) < DEPTH)}, 64'd1);
`ifdef FETCH_ZERO_HALT_EN
        if (since >= 2 && qpc.size() == 0) chk("halted_set", {63'd0, halted}, 64'd1);
        if (!gen_done) chk("halted_clear", {63'd0, halted}, 64'd0);
`endif
        if (out_valid && qpc.size() > 0) begin
          chk("out_pc", {48'd0, out_pc}, {48'd0, qpc[0]});
          chk("out_instr", {32'd0, out_instr}, {32'd0, qins[0]});
          if (out_ready) begin
            void'(qpc.pop_front());
            void'(qins.pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;
    out_ready = 1'b1;
    branch_valid = 1'b0;
    branch_target = '0;
    reset = 1'b1;

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // Redirect while the FIFO is full under backpressure.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 16'd10, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

    // Out-of-range target reduced modulo depth, then wrap-around from 30.
    step(1, 1, 16'h0025, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 1, 16'd30, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // Back-to-back redirects: the last one wins.
    step(1, 1, 16'd3, 0);
    step(1, 1, 16'd20, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    // Mid-stream reset with the FIFO full.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

    // Randomized traffic with nonzero memory contents.
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
    step(1, 0, 0, 1);
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, AW'($urandom),
           $urandom_range(0, 79) == 0);
    end

`ifdef FETCH_ZERO_HALT_EN
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;
    mem[5] = '0;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step($urandom_range(0, 1) == 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    step(1, 1, 16'd10, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 1, 16'd3, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
`endif

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
